// File: rtl/rnd_ctrl.sv
// rnd_ctrl: sequencer for the FPU rounding datapath.
// Walks one request through normalize (NORM_CYC cycles), significand round
// and exponent adjust, returns the per-result exception bits over a
// valid/ready handshake, keeps sticky IEEE flags and pulses trap for
// enabled overflow/underflow.
// Optional feature: define RND_CTRL_STATS_EN to add the stat_ops/stat_ovf
// saturating statistics counters (CNT_W bits wide).
module rnd_ctrl #(
    parameter int NORM_CYC = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_db,
    input  logic             req_ovfen,
    input  logic             req_unfen,
    output logic             norm_en,
    output logic             rnd_en,
    output logic             adj_en,
    output logic             dp_db,
    output logic             dp_ovfen,
    input  logic             dp_sigovf,
    input  logic             dp_ovf,
    input  logic             dp_unf,
    input  logic             dp_inx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ovf,
    output logic             res_unf,
    output logic             res_inx,
    output logic             res_sigovf,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inx,
    input  logic             flag_clr,
    output logic             trap,
    output logic             busy
`ifdef RND_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_ops,
    output logic [CNT_W-1:0] stat_ovf
`endif
);

    // Reject configurations the 2-bit normalize counter cannot represent.
    if (NORM_CYC < 1 || NORM_CYC > 4 || CNT_W < 1) begin : g_bad_param
        $error("rnd_ctrl: NORM_CYC must be in 1..4 and CNT_W must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NORM = 3'd1,
        ST_RND  = 3'd2,
        ST_ADJ  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] NORM_LOAD = 2'(NORM_CYC - 1);

    state_t     state_r;
    logic [1:0] cnt_r;
    logic       req_ready_r;
    logic       norm_en_r;
    logic       rnd_en_r;
    logic       adj_en_r;
    logic       db_r;
    logic       ovfen_r;
    logic       unfen_r;
    logic       res_valid_r;
    logic       res_ovf_r;
    logic       res_unf_r;
    logic       res_inx_r;
    logic       res_sigovf_r;
    logic       flag_ovf_r;
    logic       flag_unf_r;
    logic       flag_inx_r;
    logic       trap_r;
    logic       busy_r;

    logic       adj_s;
    logic       set_ovf_s;
    logic       set_unf_s;
    logic       set_inx_s;

    // Exception indications are only meaningful while the adjust stage runs.
    always_comb begin
        adj_s     = 1'b0;
        set_ovf_s = 1'b0;
        set_unf_s = 1'b0;
        set_inx_s = 1'b0;
        if (state_r == ST_ADJ) begin
            adj_s     = 1'b1;
            set_ovf_s = dp_ovf;
            set_unf_s = dp_unf;
            set_inx_s = dp_inx;
        end else begin
            adj_s     = 1'b0;
        end
    end

    // Sequencer: state, stage enables, handshakes and captured result bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 2'd0;
            req_ready_r  <= 1'b1;
            norm_en_r    <= 1'b0;
            rnd_en_r     <= 1'b0;
            adj_en_r     <= 1'b0;
            db_r         <= 1'b0;
            ovfen_r      <= 1'b0;
            unfen_r      <= 1'b0;
            res_valid_r  <= 1'b0;
            res_ovf_r    <= 1'b0;
            res_unf_r    <= 1'b0;
            res_inx_r    <= 1'b0;
            res_sigovf_r <= 1'b0;
            trap_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            trap_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_r     <= ST_NORM;
                        db_r        <= req_db;
                        ovfen_r     <= req_ovfen;
                        unfen_r     <= req_unfen;
                        cnt_r       <= NORM_LOAD;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        norm_en_r   <= 1'b1;
                    end
                end
                ST_NORM: begin
                    if (cnt_r == 2'd0) begin
                        state_r   <= ST_RND;
                        norm_en_r <= 1'b0;
                        rnd_en_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                ST_RND: begin
                    res_sigovf_r <= dp_sigovf;
                    state_r      <= ST_ADJ;
                    rnd_en_r     <= 1'b0;
                    adj_en_r     <= 1'b1;
                end
                ST_ADJ: begin
                    res_ovf_r   <= dp_ovf;
                    res_unf_r   <= dp_unf;
                    res_inx_r   <= dp_inx;
                    trap_r      <= (dp_ovf & ovfen_r) | (dp_unf & unfen_r);
                    adj_en_r    <= 1'b0;
                    res_valid_r <= 1'b1;
                    state_r     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state_r     <= ST_IDLE;
                        res_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 2'd0;
                    norm_en_r   <= 1'b0;
                    rnd_en_r    <= 1'b0;
                    adj_en_r    <= 1'b0;
                    res_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a flag being set in ADJ wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_ovf_r <= 1'b0;
            flag_unf_r <= 1'b0;
            flag_inx_r <= 1'b0;
        end else begin
            flag_ovf_r <= (flag_ovf_r & ~flag_clr) | set_ovf_s;
            flag_unf_r <= (flag_unf_r & ~flag_clr) | set_unf_s;
            flag_inx_r <= (flag_inx_r & ~flag_clr) | set_inx_s;
        end
    end

`ifdef RND_CTRL_STATS_EN
    logic [CNT_W-1:0] stat_ops_r;
    logic [CNT_W-1:0] stat_ovf_r;

    // Saturating operation / overflow counters, cleared alongside the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_r <= '0;
            stat_ovf_r <= '0;
        end else begin
            if (flag_clr) begin
                stat_ops_r <= adj_s ? CNT_W'(1) : '0;
                stat_ovf_r <= set_ovf_s ? CNT_W'(1) : '0;
            end else begin
                if (adj_s && (stat_ops_r != {CNT_W{1'b1}})) begin
                    stat_ops_r <= stat_ops_r + CNT_W'(1);
                end
                if (set_ovf_s && (stat_ovf_r != {CNT_W{1'b1}})) begin
                    stat_ovf_r <= stat_ovf_r + CNT_W'(1);
                end
            end
        end
    end

    assign stat_ops = stat_ops_r;
    assign stat_ovf = stat_ovf_r;
`endif

    assign req_ready  = req_ready_r;
    assign norm_en    = norm_en_r;
    assign rnd_en     = rnd_en_r;
    assign adj_en     = adj_en_r;
    assign dp_db      = db_r;
    assign dp_ovfen   = ovfen_r;
    assign res_valid  = res_valid_r;
    assign res_ovf    = res_ovf_r;
    assign res_unf    = res_unf_r;
    assign res_inx    = res_inx_r;
    assign res_sigovf = res_sigovf_r;
    assign flag_ovf   = flag_ovf_r;
    assign flag_unf   = flag_unf_r;
    assign flag_inx   = flag_inx_r;
    assign trap       = trap_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_rnd_ctrl.sv
// Bench for rnd_ctrl: two instances (NORM_CYC=1 and NORM_CYC=3) driven with
// directed and random requests; expected behaviour comes from a timeline
// model (stage by cycle offset from accept) plus sticky-flag bookkeeping.
module tb_rnd_ctrl;

    logic clk;
    logic rst_n;
    logic [1:0] req_valid, req_db, req_ovfen, req_unfen;
    logic [1:0] dp_sigovf, dp_ovf, dp_unf, dp_inx, res_ready, flag_clr;
    wire  [1:0] req_ready, norm_en, rnd_en, adj_en, dp_db, dp_ovfen;
    wire  [1:0] res_valid, res_ovf, res_unf, res_inx, res_sigovf;
    wire  [1:0] flag_ovf, flag_unf, flag_inx, trap, busy;
`ifdef RND_CTRL_STATS_EN
    wire  [1:0][15:0] stat_ops;
    wire  [1:0][15:0] stat_ovf;
`endif

    int ncmp  = 0;
    int nfail = 0;

    // reference model state
    bit [1:0] m_fo, m_fu, m_fi;
    bit [1:0] m_ro, m_ru, m_ri, m_rs;
    bit [1:0] m_db, m_ovfen;
    int       m_ops [2];
    int       m_ovc [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rnd_ctrl #(.NORM_CYC(g == 0 ? 1 : 3), .CNT_W(16)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_db    (req_db[g]),
            .req_ovfen (req_ovfen[g]),
            .req_unfen (req_unfen[g]),
            .norm_en   (norm_en[g]),
            .rnd_en    (rnd_en[g]),
            .adj_en    (adj_en[g]),
            .dp_db     (dp_db[g]),
            .dp_ovfen  (dp_ovfen[g]),
            .dp_sigovf (dp_sigovf[g]),
            .dp_ovf    (dp_ovf[g]),
            .dp_unf    (dp_unf[g]),
            .dp_inx    (dp_inx[g]),
            .res_valid (res_valid[g]),
            .res_ready (res_ready[g]),
            .res_ovf   (res_ovf[g]),
            .res_unf   (res_unf[g]),
            .res_inx   (res_inx[g]),
            .res_sigovf(res_sigovf[g]),
            .flag_ovf  (flag_ovf[g]),
            .flag_unf  (flag_unf[g]),
            .flag_inx  (flag_inx[g]),
            .flag_clr  (flag_clr[g]),
            .trap      (trap[g]),
            .busy      (busy[g])
`ifdef RND_CTRL_STATS_EN
            ,
            .stat_ops  (stat_ops[g]),
            .stat_ovf  (stat_ovf[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nc_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // e = {req_ready, norm_en, rnd_en, adj_en, res_valid, busy, trap}
    task automatic check_unit(input int u, input string ph, input logic [6:0] e);
        string t;
        t = $sformatf("u%0d %s", u, ph);
        chk({t, " req_ready"}, 32'(req_ready[u]), 32'(e[6]));
        chk({t, " norm_en"},   32'(norm_en[u]),   32'(e[5]));
        chk({t, " rnd_en"},    32'(rnd_en[u]),    32'(e[4]));
        chk({t, " adj_en"},    32'(adj_en[u]),    32'(e[3]));
        chk({t, " res_valid"}, 32'(res_valid[u]), 32'(e[2]));
        chk({t, " busy"},      32'(busy[u]),      32'(e[1]));
        chk({t, " trap"},      32'(trap[u]),      32'(e[0]));
        chk({t, " flag_ovf"},  32'(flag_ovf[u]),  32'(m_fo[u]));
        chk({t, " flag_unf"},  32'(flag_unf[u]),  32'(m_fu[u]));
        chk({t, " flag_inx"},  32'(flag_inx[u]),  32'(m_fi[u]));
        chk({t, " res_ovf"},   32'(res_ovf[u]),   32'(m_ro[u]));
        chk({t, " res_unf"},   32'(res_unf[u]),   32'(m_ru[u]));
        chk({t, " res_inx"},   32'(res_inx[u]),   32'(m_ri[u]));
        chk({t, " res_sigovf"},32'(res_sigovf[u]),32'(m_rs[u]));
        if (e[1]) begin
            chk({t, " dp_db"},    32'(dp_db[u]),    32'(m_db[u]));
            chk({t, " dp_ovfen"}, 32'(dp_ovfen[u]), 32'(m_ovfen[u]));
        end
`ifdef RND_CTRL_STATS_EN
        chk({t, " stat_ops"}, 32'(stat_ops[u]), 32'(m_ops[u]));
        chk({t, " stat_ovf"}, 32'(stat_ovf[u]), 32'(m_ovc[u]));
`endif
    endtask

    task automatic rand_dp(input int u);
        dp_sigovf[u] = 1'($urandom);
        dp_ovf[u]    = 1'($urandom);
        dp_unf[u]    = 1'($urandom);
        dp_inx[u]    = 1'($urandom);
    endtask

    task automatic model_reset();
        m_fo = '0; m_fu = '0; m_fi = '0;
        m_ro = '0; m_ru = '0; m_ri = '0; m_rs = '0;
        m_db = '0; m_ovfen = '0;
        for (int i = 0; i < 2; i++) begin
            m_ops[i] = 0;
            m_ovc[i] = 0;
        end
    endtask

    // One request on unit u, starting in IDLE at a negedge; ends back in IDLE.
    task automatic do_op(input int u, input bit db, input bit ovfen, input bit unfen,
                         input bit sg, input bit ov, input bit un, input bit ix,
                         input int hold, input bit clr_adj);
        int nc;
        bit etrap;
        nc = nc_of(u);
        etrap = (ov & ovfen) | (un & unfen);
        flag_clr = 2'b00;
        req_valid[u] = 1'b1;
        req_db[u] = db;
        req_ovfen[u] = ovfen;
        req_unfen[u] = unfen;
        res_ready[u] = 1'($urandom);
        rand_dp(u);
        m_db[u] = db;
        m_ovfen[u] = ovfen;
        for (int k = 1; k <= nc + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == nc + 2) m_rs[u] = sg;
            if (k == nc + 3) begin
                m_ro[u] = ov; m_ru[u] = un; m_ri[u] = ix;
                if (clr_adj) begin
                    m_fo[u] = ov; m_fu[u] = un; m_fi[u] = ix;
                    m_ops[u] = 1; m_ovc[u] = ov ? 1 : 0;
                end else begin
                    m_fo[u] |= ov; m_fu[u] |= un; m_fi[u] |= ix;
                    m_ops[u]++; m_ovc[u] += ov ? 1 : 0;
                end
            end
            if (k <= nc)          check_unit(u, $sformatf("norm%0d", k), 7'b0100010);
            else if (k == nc + 1) check_unit(u, "rnd", 7'b0010010);
            else if (k == nc + 2) check_unit(u, "adj", 7'b0001010);
            else                  check_unit(u, "done", {6'b000011, etrap});
            // inputs below are ignored by the DUT except where the stage samples them
            req_valid[u] = 1'b1;
            req_db[u] = 1'($urandom);
            req_ovfen[u] = 1'($urandom);
            req_unfen[u] = 1'($urandom);
            rand_dp(u);
            res_ready[u] = 1'($urandom);
            flag_clr[u] = 1'b0;
            if (k == nc + 1) dp_sigovf[u] = sg;
            if (k == nc + 2) begin
                dp_ovf[u] = ov; dp_unf[u] = un; dp_inx[u] = ix;
                flag_clr[u] = clr_adj;
            end
            if (k == nc + 3) res_ready[u] = (hold == 0);
        end
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_unit(u, "hold", 7'b0000110);
            rand_dp(u);
            res_ready[u] = (h == hold);
        end
        @(posedge clk);
        @(negedge clk);
        check_unit(u, "ret", 7'b1000000);
        res_ready[u] = 1'b0;
        req_valid[u] = 1'b0;
    endtask

    // Idle cycles on both units with random flag_clr and noise on dp inputs.
    task automatic idle(input int n);
        logic [1:0] clr;
        for (int i = 0; i < n; i++) begin
            req_valid = 2'b00;
            res_ready = 2'($urandom);
            req_db = 2'($urandom);
            clr[0] = ($urandom_range(0, 3) == 0);
            clr[1] = ($urandom_range(0, 3) == 0);
            flag_clr = clr;
            rand_dp(0);
            rand_dp(1);
            @(posedge clk);
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                if (clr[u]) begin
                    m_fo[u] = 1'b0; m_fu[u] = 1'b0; m_fi[u] = 1'b0;
                    m_ops[u] = 0; m_ovc[u] = 0;
                end
                check_unit(u, "idle", 7'b1000000);
            end
        end
        flag_clr = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_db = '0; req_ovfen = '0; req_unfen = '0;
        dp_sigovf = '0; dp_ovf = '0; dp_unf = '0; dp_inx = '0;
        res_ready = '0; flag_clr = '0;
        model_reset();
        @(negedge clk);
        check_unit(0, "reset", 7'b1000000);
        check_unit(1, "reset", 7'b1000000);
        rst_n = 1'b1;
        idle(2);

        // NORM_CYC=1 basic flow: ovf without trap enable
        do_op(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        // ovf trap, unf trap, inexact never traps
        do_op(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_op(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        do_op(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(2);
        // NORM_CYC=3, back-to-back requests with req_valid held high
        do_op(1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        do_op(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        // result held in DONE for 10 cycles
        do_op(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10, 1'b0);
        idle(1);
        // flag_clr coinciding with ADJ: inexact set wins, overflow cleared
        do_op(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_op(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        chk("clr_adj flag_inx", 32'(flag_inx[0]), 32'd1);
        chk("clr_adj flag_ovf", 32'(flag_ovf[0]), 32'd0);

        // random traffic
        for (int r = 0; r < 40; r++) begin
            int u;
            u = $urandom_range(0, 1);
            do_op(u, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        // asynchronous reset while unit 0 is in RND
        idle(1);
        req_valid[0] = 1'b1; req_db[0] = 1'b1; req_ovfen[0] = 1'b1; req_unfen[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        chk("pre-rst rnd_en", 32'(rnd_en[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_unit(0, "async_rst", 7'b1000000);
        check_unit(1, "async_rst", 7'b1000000);
        chk("async_rst dp_db", 32'(dp_db[0]), 32'd0);
        chk("async_rst dp_ovfen", 32'(dp_ovfen[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/rnd_ctrl.md
Name: rnd_ctrl

Overview:
Sequencer for the FPU rounding datapath: normalize shift, significand round, and exponent adjust (adjexp).
- Accepts one rounding request at a time over a valid/ready handshake.
- Steps the datapath stages with one-hot stage enables and samples the overflow/underflow/inexact indications the datapath returns.
- Presents a result handshake, maintains sticky IEEE exception flags, and raises a trap pulse for enabled exceptions.

Parameters:
NORM_CYC, 1, cycles the normalize stage enable is held (1..4)
CNT_W, 16, width of statistics counters (used only with RND_CTRL_STATS_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  rounding request present
req_ready  out  1  request accepted when req_valid & req_ready
req_db  in  1  1 = double precision, 0 = single
req_ovfen  in  1  overflow trap enable
req_unfen  in  1  underflow trap enable
norm_en  out  1  normalize stage enable
rnd_en  out  1  significand round stage enable
adj_en  out  1  exponent adjust stage enable
dp_db  out  1  latched precision driven to datapath
dp_ovfen  out  1  latched OVFen driven to adjexp
dp_sigovf  in  1  significand overflow from round stage, valid during RND
dp_ovf  in  1  OVF from adjexp, valid during ADJ
dp_unf  in  1  underflow indication, valid during ADJ
dp_inx  in  1  inexact indication, valid during ADJ
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_ovf  out  1  overflow of current result
res_unf  out  1  underflow of current result
res_inx  out  1  inexact of current result
res_sigovf  out  1  captured sigovf of current result
flag_ovf  out  1  sticky overflow
flag_unf  out  1  sticky underflow
flag_inx  out  1  sticky inexact
flag_clr  in  1  synchronous clear of sticky flags
trap  out  1  one-cycle pulse: enabled exception occurred
busy  out  1  state != IDLE

Behaviour:
States: IDLE, NORM, RND, ADJ, DONE. Registered state.
- Reset (asynchronous, any state, mid-operation included):
  - State goes to IDLE.
  - All outputs go to 0 except req_ready, which is 1.
  - Latched db/ovfen/unfen, captured result bits, sticky flags and counters all clear to 0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_db/req_ovfen/req_unfen, load the cycle counter with NORM_CYC-1, go to NORM.
- NORM:
  - norm_en=1.
  - The counter decrements each cycle; at 0, go to RND.
  - NORM therefore lasts exactly NORM_CYC cycles.
- RND:
  - rnd_en=1 for 1 cycle.
  - Capture dp_sigovf into res_sigovf; go to ADJ.
- ADJ:
  - adj_en=1 for 1 cycle.
  - Capture dp_ovf, dp_unf, dp_inx into the res_* registers.
  - OR each of those into its sticky flag.
  - Go to DONE.
- DONE:
  - res_valid=1; res_* held stable until handshake.
  - On res_ready go to IDLE; res_* keep their last values.
- Control outputs:
  - Stage enables are decoded from state, mutually exclusive, and never asserted in IDLE or DONE.
  - dp_db and dp_ovfen are constant from acceptance until return to IDLE.
- Latency: request accept to res_valid = NORM_CYC+2 cycles. Minimum request-to-request spacing is NORM_CYC+4 cycles: one bubble in IDLE, and req_ready is low in DONE.
- trap:
  - Registered; pulses high for exactly one cycle, the cycle after ADJ.
  - Condition: (dp_ovf & latched ovfen) | (dp_unf & latched unfen).
  - Inexact never traps.
- flag_clr:
  - Clears all sticky flags next edge.
  - If flag_clr coincides with an ADJ cycle setting a flag, the set wins for that flag; flags not being set are cleared.
- Ignored inputs:
  - req_valid outside IDLE is ignored; no queueing.
  - res_ready outside DONE is ignored.
  - dp_* inputs outside their stated valid state are ignored.

Optional Feature:
Macro RND_CTRL_STATS_EN.
- Defined: adds outputs stat_ops (CNT_W) and stat_ovf (CNT_W).
  - stat_ops increments on each ADJ cycle.
  - stat_ovf increments on each ADJ cycle with dp_ovf=1.
  - Both saturate at all-ones and clear on reset or flag_clr.
  - If flag_clr coincides with an increment, the counter loads 1.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- NORM_CYC=1; request db=1, ovfen=0; dp_sigovf=1 in RND; dp_ovf=1 in ADJ -> norm_en, rnd_en, adj_en each high 1 cycle in order; res_valid 3 cycles after accept; res_ovf=1, res_sigovf=1, flag_ovf=1, trap stays 0.
- Request with ovfen=1, dp_ovf=1 -> trap high exactly 1 cycle, the cycle after ADJ; repeat with unfen=1, dp_unf=1 -> same; dp_inx=1 alone -> no trap, flag_inx=1.
- NORM_CYC=3 -> norm_en high 3 consecutive cycles; res_valid 5 cycles after accept; req_valid held high throughout -> only one accept; next accept 1 cycle after the DONE handshake.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid and res_* stable, req_ready=0, no stage enable asserted; res_ready=1 -> IDLE next cycle.
- flag_clr asserted in the same cycle as an ADJ with dp_inx=1, and flag_ovf previously 1 -> flag_inx=1, flag_ovf=0.
- Deassert rst_n during RND -> immediately IDLE, all enables 0, flags 0, req_ready=1; with RND_CTRL_STATS_EN, stat_ops=0.
